reset_release_sequencer: RTL and testbench
==========================================

# reset_release_sequencer

Synthesizable, parametrised bring-up sequencer that holds up to eight downstream reset domains in reset and releases them one at a time. Each stage is released only after the previous stage reports completion, such as DDR calibration complete or PCIe link up, plus a programmable gap. It replaces simulation-only force/release bring-up of host-done and calibration gating with a deterministic, retryable, on-chip sequence. It sits between the board reset and the per-domain reset inputs of the system top.

## Interface
- NUM_STAGES, 3, number of sequenced reset domains; legal range 1..8.
- HOLD_CYCLES, 500, initial all-reset hold and inter-stage gap, in clock cycles; must be at least 1.
- TIMEOUT_CYCLES, 65535, maximum cycles to wait for a stage's done signal; used only with the timeout feature.
- CNT_W, 16, counter width; must hold max(HOLD_CYCLES, TIMEOUT_CYCLES).

- clock, in, 1, sole clock.
- reset, in, 1, asynchronous, active-high.
- ext_rst_req, in, 1, synchronous soft restart request (level).
- stage_done, in, NUM_STAGES, per-stage completion; asynchronous to clock.
- stage_rst, out, NUM_STAGES, per-stage reset, active-high.
- all_done, out, 1, every stage released and done.
- busy, out, 1, sequence in progress (high whenever all_done is low).
- cur_stage, out, 3, index of the stage currently waited on or gapped.
- timeout_err, out, 1, sticky timeout flag.
- err_stage, out, 3, stage that timed out.

## Operation
- stage_done passes through a 2-flop synchronizer per bit. "done[k]" below means the synchronized value.
- State machine states: ASSERT, WAIT(k), GAP(k), DONE. All outputs are registered.
- Reset values: state ASSERT, counter 0, stage_rst all 1, all_done 0, busy 1, cur_stage 0, timeout_err 0, err_stage 0.
- ASSERT:
  - Force all stage_rst high and count.
  - When count == HOLD_CYCLES-1: clear stage_rst[0], clear the counter, go to WAIT(0).
- WAIT(k):
  - If done[k] = 1: go to GAP(k) (or DONE if k == NUM_STAGES-1) and clear the counter.
  - The minimum dwell is 1 cycle, even if done[k] is already high.
- GAP(k):
  - When count == HOLD_CYCLES-1: clear stage_rst[k+1], go to WAIT(k+1).
  - If done[k] drops during GAP: go to ASSERT.
- DONE:
  - all_done = 1, busy = 0.
  - If any done[j] drops: go to ASSERT. This is a full re-sequence, and all stage_rst return high on the next edge.
- ext_rst_req = 1 in any state:
  - Next state is ASSERT with the counter cleared; the request is held in ASSERT for as long as it stays high.
  - Also clears timeout_err and err_stage.
  - It has priority over all other transitions.
- A released stage never re-enters reset, except via a transition to ASSERT.
- The counter saturates at its maximum value and never wraps.

## Timing
- Stage release is registered: stage_rst[k] falls on the edge on which the state enters WAIT(k).
- stage_done to the internal done signal: 2-cycle synchronizer latency.
- done[k] sampled high in WAIT(k) leads to a gap of HOLD_CYCLES cycles, then stage_rst[k+1] falls.
- With all done inputs already high: stage_rst[0] falls HOLD_CYCLES edges after reset deasserts, and each later stage falls HOLD_CYCLES+1 edges after the previous one.
- all_done rises 1 edge after WAIT(last) samples done.
- Reset asserted mid-sequence: all stage_rst go high immediately (asynchronously).

## Configuration
- RSTSEQ_TIMEOUT_EN defined:
  - In WAIT(k), the counter runs.
  - At count == TIMEOUT_CYCLES-1 without done[k]: set timeout_err, set err_stage = k, go to ASSERT (automatic retry).
  - timeout_err stays set across retries and later success.
- RSTSEQ_TIMEOUT_EN not defined:
  - WAIT(k) waits indefinitely.
  - timeout_err and err_stage are tied to 0.
  - TIMEOUT_CYCLES is ignored.

## Test plan
All scenarios use NUM_STAGES=3, HOLD_CYCLES=4, TIMEOUT_CYCLES=20.
- Nominal, stage_done tied 3'b111: stage_rst falls at edges 4, 9 and 14 after reset release; all_done rises at edge 15; cur_stage steps 0→1→2.
- Stage 1 done arrives late (stage_done[1] raised 30 cycles after stage_rst[1] falls), timeout undefined: stage_rst[2] stays high until 2+1+4 cycles after stage_done[1] rises; no error.
- RSTSEQ_TIMEOUT_EN defined, stage_done[1] held 0: 20 cycles after entering WAIT(1), timeout_err=1, err_stage=1, all stage_rst return high; the sequence restarts and repeats. Then raise stage_done[1]: all_done=1 and timeout_err remains 1.
- In DONE, pulse stage_done[0] low for 5 cycles: all_done falls; all stage_rst high on the edge after the synchronized drop; full re-sequence to all_done.
- ext_rst_req high for 10 cycles during GAP(1): stage_rst=3'b111 within 1 edge; the hold restarts only after ext_rst_req falls; timeout_err is cleared.
- Asynchronous reset asserted mid-GAP(0) with no clock edge: stage_rst immediately 3'b111, all_done 0.

Source files
------------

// File: rtl/reset_release_sequencer_if.sv
// reset_release_sequencer_if
//
// This interface groups the sequencer's handshake signals. The sequencer
// drives the per-stage resets and the status outputs. The system side drives
// the completion inputs and the soft restart request.
//
// Signals:
//   ext_rst_req  synchronous soft restart request (level)
//   stage_done   per-stage completion, asynchronous to the clock
//   stage_rst    per-stage reset, active-high
//   all_done     every stage has been released and reports done
//   busy         a sequence is in progress (inverse of all_done)
//   cur_stage    stage currently being waited on or gapped
//   timeout_err  sticky flag: a stage timed out
//   err_stage    stage that timed out
//
// Modports:
//   master  the sequencer itself
//   slave   the system top that consumes the resets
interface reset_release_sequencer_if #(
  parameter int NUM_STAGES = 3
);
  logic                  ext_rst_req;
  logic [NUM_STAGES-1:0] stage_done;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  all_done;
  logic                  busy;
  logic [2:0]            cur_stage;
  logic                  timeout_err;
  logic [2:0]            err_stage;

  modport master (
    input  ext_rst_req, stage_done,
    output stage_rst, all_done, busy, cur_stage, timeout_err, err_stage
  );

  modport slave (
    output ext_rst_req, stage_done,
    input  stage_rst, all_done, busy, cur_stage, timeout_err, err_stage
  );
endinterface

// File: rtl/reset_release_sequencer.sv
// reset_release_sequencer
//
// This module holds up to eight downstream reset domains in reset after power-up.
// It then releases them one at a time. Each domain is released only after the
// previous domain reports completion, for example calibration complete or link up.
// A programmable gap follows that report. If a completed domain later drops its
// done signal, the whole bring-up runs again from the start.
//
// Ports:
//   clock  sole clock
//   reset  asynchronous, active-high; forces every stage_rst high at once
//   bus    reset_release_sequencer_if.master (see the interface for the
//          signal list)
//
// Optional feature macro: RSTSEQ_TIMEOUT_EN
//   When defined, each wait for a stage's done signal is bounded by
//   TIMEOUT_CYCLES. On expiry the sequencer sets the sticky timeout_err flag,
//   records err_stage and restarts the whole sequence.
//   When undefined, a stage may take as long as it likes. In that case
//   timeout_err and err_stage are tied to 0.
module reset_release_sequencer #(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  reset_release_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_WAIT,
    ST_GAP,
    ST_DONE
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [2:0]       LAST_STAGE = 3'(NUM_STAGES - 1);

  // Catch parameter combinations that cannot work at elaboration time.
  // Without this check, such a combination would produce a sequencer that
  // silently misbehaves.
  if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
    $error("reset_release_sequencer: NUM_STAGES must be 1..8");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("reset_release_sequencer: HOLD_CYCLES must be at least 1");
  end
  if (HOLD_CYCLES > (2 ** CNT_W) || TIMEOUT_CYCLES > (2 ** CNT_W)) begin : g_bad_width
    $error("reset_release_sequencer: CNT_W too narrow for the cycle counts");
  end

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [NUM_STAGES-1:0] stage_rst_q;
  logic                  all_done_q;
  logic                  busy_q;
  logic [2:0]            cur_stage_q;

  logic [NUM_STAGES-1:0] done_meta;
  logic [NUM_STAGES-1:0] done_sync;
  logic [7:0]            done_pad;
  logic                  done_k;
  logic                  all_sync;
  logic                  timeout_hit;
  logic                  restart;
  logic [2:0]            next_stage;
  logic [NUM_STAGES-1:0] rel_mask;
  logic [CNT_W-1:0]      cnt_inc;

  // The stage_done inputs come from unrelated clock domains.
  // Each bit therefore passes through its own two-flop synchronizer before
  // the state machine looks at it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_meta <= '0;
      done_sync <= '0;
    end else begin
      done_meta <= bus.stage_done;
      done_sync <= done_meta;
    end
  end

  // This block decodes the conditions that throw the sequencer back to the
  // all-in-reset state.
  // The done vector is zero-padded to eight bits. The current-stage index
  // can then select from it for any NUM_STAGES.
  // The next stage's release mask is also precomputed here.
  always_comb begin
    done_pad    = 8'(done_sync);
    done_k      = done_pad[cur_stage_q];
    all_sync    = &done_sync;
    next_stage  = cur_stage_q + 3'd1;
    rel_mask    = NUM_STAGES'(1) << next_stage;
    cnt_inc     = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    timeout_hit = 1'b0;
`ifdef RSTSEQ_TIMEOUT_EN
    timeout_hit = (state == ST_WAIT) && !done_k && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif
    restart     = bus.ext_rst_req
                | ((state == ST_GAP)  && !done_k)
                | ((state == ST_DONE) && !all_sync)
                | timeout_hit;
  end

  // This is the main sequencing state machine. Every output is a flop.
  // A restart from any source returns every domain to reset on the same edge.
  // While ext_rst_req stays high, the restart keeps firing. That pins the
  // hold counter at zero until the request is released.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      stage_rst_q <= '1;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b1;
      cur_stage_q <= 3'd0;
    end else if (restart) begin
      state       <= ST_ASSERT;
      cnt         <= '0;
      stage_rst_q <= '1;
      all_done_q  <= 1'b0;
      busy_q      <= 1'b1;
      cur_stage_q <= 3'd0;
    end else begin
      case (state)
        ST_ASSERT: begin
          stage_rst_q <= '1;
          if (cnt == HOLD_LAST) begin
            stage_rst_q <= ~NUM_STAGES'(1);
            cnt         <= '0;
            cur_stage_q <= 3'd0;
            state       <= ST_WAIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_WAIT: begin
          if (done_k) begin
            cnt <= '0;
            if (cur_stage_q == LAST_STAGE) begin
              state      <= ST_DONE;
              all_done_q <= 1'b1;
              busy_q     <= 1'b0;
            end else begin
              state <= ST_GAP;
            end
          end else begin
`ifdef RSTSEQ_TIMEOUT_EN
            cnt <= cnt_inc;
`else
            cnt <= cnt;
`endif
          end
        end
        ST_GAP: begin
          if (cnt == HOLD_LAST) begin
            stage_rst_q <= stage_rst_q & ~rel_mask;
            cur_stage_q <= next_stage;
            cnt         <= '0;
            state       <= ST_WAIT;
          end else begin
            cnt <= cnt_inc;
          end
        end
        ST_DONE: begin
          all_done_q <= 1'b1;
          busy_q     <= 1'b0;
        end
        default: begin
          state       <= ST_ASSERT;
          cnt         <= '0;
          stage_rst_q <= '1;
        end
      endcase
    end
  end

`ifdef RSTSEQ_TIMEOUT_EN
  logic       timeout_err_q;
  logic [2:0] err_stage_q;

  // The timeout flag is sticky. It survives automatic retries and later
  // success, so that software can see that bring-up was not clean.
  // Only a soft restart request or the hard reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err_q <= 1'b0;
      err_stage_q   <= 3'd0;
    end else if (bus.ext_rst_req) begin
      timeout_err_q <= 1'b0;
      err_stage_q   <= 3'd0;
    end else if (timeout_hit) begin
      timeout_err_q <= 1'b1;
      err_stage_q   <= cur_stage_q;
    end
  end

  assign bus.timeout_err = timeout_err_q;
  assign bus.err_stage   = err_stage_q;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.err_stage   = 3'd0;
`endif

  assign bus.stage_rst = stage_rst_q;
  assign bus.all_done  = all_done_q;
  assign bus.busy      = busy_q;
  assign bus.cur_stage = cur_stage_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// tb_reset_release_sequencer
//
// This is a directed bench for reset_release_sequencer, configured with
// NUM_STAGES=3, HOLD_CYCLES=4 and TIMEOUT_CYCLES=20.
// Expected values are hand-computed edge counts, taken from reset or request
// release.
// The late-done scenario runs in the default build. The retry scenario runs
// when RSTSEQ_TIMEOUT_EN is defined.
module tb_reset_release_sequencer;

  localparam int NUM_STAGES = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  reset_release_sequencer_if #(.NUM_STAGES(NUM_STAGES)) bus ();

  reset_release_sequencer #(
    .NUM_STAGES     (NUM_STAGES),
    .HOLD_CYCLES    (4),
    .TIMEOUT_CYCLES (20),
    .CNT_W          (16)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // 100 MHz free-running clock.
  always #5 clock = ~clock;

  // This is a watchdog, so that a stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance n rising edges. Stimulus is driven and outputs are sampled
  // 1 ns after each edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic ext,
                               input logic [NUM_STAGES-1:0] done);
    reset           = rst;
    bus.ext_rst_req = ext;
    bus.stage_done  = done;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // This task waits, within a cycle budget, for all_done. It then compares
  // all_done with 1, so an expired budget shows up as a failed check.
  task automatic waitAllDone(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (bus.all_done === 1'b1) break;
      step(1);
    end
    checkOutput(tag, 8'(bus.all_done), 8'h1);
  endtask

  initial begin
    // ---------------- reset state ----------------
    applyStimulus(1'b1, 1'b0, 3'b111);
    step(2);
    checkOutput("rst_stage_rst",   8'(bus.stage_rst),   8'h7);
    checkOutput("rst_all_done",    8'(bus.all_done),    8'h0);
    checkOutput("rst_busy",        8'(bus.busy),        8'h1);
    checkOutput("rst_cur_stage",   8'(bus.cur_stage),   8'h0);
    checkOutput("rst_timeout_err", 8'(bus.timeout_err), 8'h0);
    checkOutput("rst_err_stage",   8'(bus.err_stage),   8'h0);

    // ---------------- nominal, all done tied high ----------------
    applyStimulus(1'b0, 1'b0, 3'b111);
    step(3);
    checkOutput("nom_e3_rst", 8'(bus.stage_rst), 8'h7);
    step(1);
    checkOutput("nom_e4_rst", 8'(bus.stage_rst), 8'h6);
    checkOutput("nom_e4_cur", 8'(bus.cur_stage), 8'h0);
    step(4);
    checkOutput("nom_e8_rst", 8'(bus.stage_rst), 8'h6);
    step(1);
    checkOutput("nom_e9_rst", 8'(bus.stage_rst), 8'h4);
    checkOutput("nom_e9_cur", 8'(bus.cur_stage), 8'h1);
    step(4);
    checkOutput("nom_e13_rst", 8'(bus.stage_rst), 8'h4);
    step(1);
    checkOutput("nom_e14_rst",  8'(bus.stage_rst), 8'h0);
    checkOutput("nom_e14_cur",  8'(bus.cur_stage), 8'h2);
    checkOutput("nom_e14_done", 8'(bus.all_done),  8'h0);
    step(1);
    checkOutput("nom_e15_done", 8'(bus.all_done),  8'h1);
    checkOutput("nom_e15_busy", 8'(bus.busy),      8'h0);

    // ---------------- done drop while in DONE ----------------
    applyStimulus(1'b0, 1'b0, 3'b110);
    step(2);
    checkOutput("drop_sync_done", 8'(bus.all_done), 8'h1);
    step(1);
    checkOutput("drop_rst",  8'(bus.stage_rst), 8'h7);
    checkOutput("drop_done", 8'(bus.all_done),  8'h0);
    checkOutput("drop_busy", 8'(bus.busy),      8'h1);
    step(2);
    applyStimulus(1'b0, 1'b0, 3'b111);
    waitAllDone("drop_reseq_done", 60);
    checkOutput("drop_reseq_rst", 8'(bus.stage_rst), 8'h0);

`ifndef RSTSEQ_TIMEOUT_EN
    // ---------------- stage 1 done arrives late ----------------
    applyStimulus(1'b1, 1'b0, 3'b101);
    step(2);
    applyStimulus(1'b0, 1'b0, 3'b101);
    step(9);
    checkOutput("late_e9_rst", 8'(bus.stage_rst), 8'h4);
    checkOutput("late_e9_cur", 8'(bus.cur_stage), 8'h1);
    step(30);
    checkOutput("late_wait_rst", 8'(bus.stage_rst), 8'h4);
    applyStimulus(1'b0, 1'b0, 3'b111);
    step(6);
    checkOutput("late_rise6_rst", 8'(bus.stage_rst), 8'h4);
    step(1);
    checkOutput("late_rise7_rst", 8'(bus.stage_rst), 8'h0);
    checkOutput("late_rise7_cur", 8'(bus.cur_stage), 8'h2);
    step(1);
    checkOutput("late_all_done",  8'(bus.all_done),    8'h1);
    checkOutput("late_no_tmo",    8'(bus.timeout_err), 8'h0);
    checkOutput("late_err_stage", 8'(bus.err_stage),   8'h0);
`else
    // ---------------- stage 1 times out and retries ----------------
    applyStimulus(1'b1, 1'b0, 3'b101);
    step(2);
    applyStimulus(1'b0, 1'b0, 3'b101);
    step(9);
    checkOutput("tmo_e9_rst", 8'(bus.stage_rst), 8'h4);
    step(19);
    checkOutput("tmo_e28_rst", 8'(bus.stage_rst),   8'h4);
    checkOutput("tmo_e28_err", 8'(bus.timeout_err), 8'h0);
    step(1);
    checkOutput("tmo_e29_err",   8'(bus.timeout_err), 8'h1);
    checkOutput("tmo_e29_stage", 8'(bus.err_stage),   8'h1);
    checkOutput("tmo_e29_rst",   8'(bus.stage_rst),   8'h7);
    step(28);
    checkOutput("tmo_e57_rst", 8'(bus.stage_rst), 8'h4);
    step(1);
    checkOutput("tmo_e58_rst", 8'(bus.stage_rst),   8'h7);
    checkOutput("tmo_e58_err", 8'(bus.timeout_err), 8'h1);
    applyStimulus(1'b0, 1'b0, 3'b111);
    waitAllDone("tmo_final_done", 60);
    checkOutput("tmo_sticky_err",   8'(bus.timeout_err), 8'h1);
    checkOutput("tmo_sticky_stage", 8'(bus.err_stage),   8'h1);
`endif

    // ---------------- async reset mid GAP(0) ----------------
    applyStimulus(1'b1, 1'b0, 3'b111);
    step(2);
    applyStimulus(1'b0, 1'b0, 3'b111);
    step(6);
    checkOutput("gap0_rst_before", 8'(bus.stage_rst), 8'h6);
    applyStimulus(1'b1, 1'b0, 3'b111);
    #1;
    checkOutput("async_rst",  8'(bus.stage_rst), 8'h7);
    checkOutput("async_done", 8'(bus.all_done),  8'h0);
    checkOutput("async_busy", 8'(bus.busy),      8'h1);
    step(1);

    // ---------------- ext_rst_req during GAP(1) ----------------
    applyStimulus(1'b0, 1'b0, 3'b111);
    step(10);
    checkOutput("gap1_rst", 8'(bus.stage_rst), 8'h4);
    checkOutput("gap1_cur", 8'(bus.cur_stage), 8'h1);
    step(1);
    applyStimulus(1'b0, 1'b1, 3'b111);
    step(1);
    checkOutput("ext_rst",     8'(bus.stage_rst),   8'h7);
    checkOutput("ext_cur",     8'(bus.cur_stage),   8'h0);
    checkOutput("ext_tmo_clr", 8'(bus.timeout_err), 8'h0);
    checkOutput("ext_stg_clr", 8'(bus.err_stage),   8'h0);
    step(9);
    checkOutput("ext_hold_rst", 8'(bus.stage_rst), 8'h7);
    applyStimulus(1'b0, 1'b0, 3'b111);
    step(3);
    checkOutput("ext_rel3_rst", 8'(bus.stage_rst), 8'h7);
    step(1);
    checkOutput("ext_rel4_rst", 8'(bus.stage_rst), 8'h6);
    waitAllDone("ext_final_done", 40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
